// File: rtl/flopenr_pkg.sv
// -----------------------------------------------------------------------------
// flopenr_pkg
// Shared constants and helpers for the flopenr_pipe pipeline slice.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and stage count
//   occ_width(depth)              : bit width needed to hold 0..depth
// -----------------------------------------------------------------------------
package flopenr_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 3;

  // Width of a counter that must represent every value from 0 to depth.
  // Clamped to 1 so a degenerate depth still yields a legal vector.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : flopenr_pkg

// File: rtl/flopenr_stage.sv
// -----------------------------------------------------------------------------
// flopenr_stage
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
// Priority at the clock edge: flush > en > hold. reset is asynchronous and
// loads RESET_VAL / invalid without waiting for a clock edge.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   en        in   load d / in_valid when high, hold when low
//   flush     in   synchronous squash to RESET_VAL / invalid
//   in_valid  in   valid bit accompanying d
//   d         in   WIDTH-bit data
//   q         out  registered data
//   valid     out  registered valid bit
// -----------------------------------------------------------------------------
module flopenr_stage
  import flopenr_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      data_d  = RESET_VAL;
      valid_d = 1'b0;
    end else if (en) begin
      data_d  = d;
      valid_d = in_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule : flopenr_stage

// File: rtl/flopenr_pipe.sv
// -----------------------------------------------------------------------------
// flopenr_pipe
// DEPTH-stage, WIDTH-bit pipeline register with per-stage valid bits, a
// global advance enable and a synchronous flush. Generic delay slice between
// datapath blocks that need stall and squash control.
//
// Flow control: a beat is (d, in_valid). It is captured only on an edge with
// en=1 and flush=0; with en=0 the upstream block must keep presenting it, since
// nothing is captured. Bubbles (in_valid=0) travel through like data, so the
// output valid pattern is the input valid pattern delayed by DEPTH enabled
// edges. Data shifts regardless of valid.
//
// Optional build macro FLOPENR_PIPE_OCC_EN adds the occ output, a registered
// count of stages currently holding a valid beat.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (all stages RESET_VAL/invalid)
//   en         in   advance enable; 0 = every stage holds
//   flush      in   synchronous squash of all stages (wins over en)
//   in_valid   in   qualifies d
//   d          in   WIDTH-bit input data
//   q          out  data of the last stage
//   out_valid  out  valid bit of the last stage
//   occ        out  valid-stage count (FLOPENR_PIPE_OCC_EN only)
// -----------------------------------------------------------------------------
module flopenr_pipe
  import flopenr_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             out_valid
`ifdef FLOPENR_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_din;
  logic [DEPTH-1:0]            stage_vin;
  logic [DEPTH-1:0][WIDTH-1:0] stage_data;
  logic [DEPTH-1:0]            stage_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_din[i] = d;
      assign stage_vin[i] = in_valid;
    end else begin : g_body
      assign stage_din[i] = stage_data[i-1];
      assign stage_vin[i] = stage_valid[i-1];
    end

    flopenr_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .flush    (flush),
      .in_valid (stage_vin[i]),
      .d        (stage_din[i]),
      .q        (stage_data[i]),
      .valid    (stage_valid[i])
    );
  end

  // Last stage is a flop, so q/out_valid have no combinational input path.
  assign q         = stage_data[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];

`ifdef FLOPENR_PIPE_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_d, occ_q;

  // Tracks the popcount of stage_valid incrementally: a shift adds the
  // incoming valid bit and drops the one leaving the last stage. The sum
  // cannot leave 0..DEPTH because it mirrors the valid bits exactly.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(stage_valid[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule : flopenr_pipe

// File: tb/tb_flopenr_pipe.sv
// -----------------------------------------------------------------------------
// tb_flopenr_pipe
// Directed bench for flopenr_pipe: a DEPTH=3 instance (main checks) and a
// DEPTH=1 instance sharing the same stimulus. Expected values are written
// out by hand for each step. Inputs change 1 time unit after the rising
// edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flopenr_pipe;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       flush;
  logic       in_valid;
  logic [3:0] d;
  logic [3:0] q;
  logic       out_valid;
  logic [3:0] q1;
  logic       out_valid1;
`ifdef FLOPENR_PIPE_OCC_EN
  logic [1:0] occ;
  logic [0:0] occ1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flopenr_pipe #(
    .WIDTH     (4),
    .DEPTH     (3),
    .RESET_VAL (4'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .d         (d),
    .q         (q),
    .out_valid (out_valid)
`ifdef FLOPENR_PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  flopenr_pipe #(
    .WIDTH     (4),
    .DEPTH     (1),
    .RESET_VAL (4'h0)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .d         (d),
    .q         (q1),
    .out_valid (out_valid1)
`ifdef FLOPENR_PIPE_OCC_EN
    ,
    .occ       (occ1)
`endif
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic f, input logic v, input logic [3:0] dv);
    en       = e;
    flush    = f;
    in_valid = v;
    d        = dv;
  endtask

  // checks on the DEPTH=3 instance
  task automatic check(input string tag, input logic [3:0] eq, input logic ev, input int eocc);
    total++;
    assert (q === eq) else begin
      bad++;
      $error("FAIL %s q: got=%h exp=%h", tag, q, eq);
    end
    total++;
    assert (out_valid === ev) else begin
      bad++;
      $error("FAIL %s out_valid: got=%b exp=%b", tag, out_valid, ev);
    end
`ifdef FLOPENR_PIPE_OCC_EN
    total++;
    assert (occ === 2'(eocc)) else begin
      bad++;
      $error("FAIL %s occ: got=%0d exp=%0d", tag, occ, eocc);
    end
`else
    if (eocc < 0) $display("unexpected occ argument %0d", eocc);
`endif
  endtask

  // checks on the DEPTH=1 instance
  task automatic check1(input string tag, input logic [3:0] eq, input logic ev, input int eocc);
    total++;
    assert (q1 === eq) else begin
      bad++;
      $error("FAIL %s q1: got=%h exp=%h", tag, q1, eq);
    end
    total++;
    assert (out_valid1 === ev) else begin
      bad++;
      $error("FAIL %s out_valid1: got=%b exp=%b", tag, out_valid1, ev);
    end
`ifdef FLOPENR_PIPE_OCC_EN
    total++;
    assert (occ1 === 1'(eocc)) else begin
      bad++;
      $error("FAIL %s occ1: got=%0d exp=%0d", tag, occ1, eocc);
    end
`else
    if (eocc < 0) $display("unexpected occ argument %0d", eocc);
`endif
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    tick();
    check("rst_hold", 4'h0, 1'b0, 0);
    check1("rst_hold1", 4'h0, 1'b0, 0);
    reset = 1'b0;

    // stream 1,2,3,4 then drain
    drive(1'b1, 1'b0, 1'b1, 4'h1); tick(); check("stream_e1", 4'h0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b1, 4'h2); tick(); check("stream_e2", 4'h0, 1'b0, 2);
    drive(1'b1, 1'b0, 1'b1, 4'h3); tick(); check("stream_e3", 4'h1, 1'b1, 3);
    drive(1'b1, 1'b0, 1'b1, 4'h4); tick(); check("stream_e4", 4'h2, 1'b1, 3);
    drive(1'b1, 1'b0, 1'b0, 4'h0); tick(); check("stream_e5", 4'h3, 1'b1, 2);
    tick(); check("stream_e6", 4'h4, 1'b1, 1);
    tick(); check("stream_empty", 4'h0, 1'b0, 0);

    // stall: load A, hold 5 cycles (input changes are ignored), then advance
    drive(1'b1, 1'b0, 1'b1, 4'hA); tick(); check("stall_load", 4'h0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b1, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick(); check("stall_hold", 4'h0, 1'b0, 1);
    end
    drive(1'b1, 1'b0, 1'b0, 4'h0); tick(); check("stall_adv1", 4'h0, 1'b0, 1);
    tick(); check("stall_emerge", 4'hA, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b1, 4'h5);
    tick(); check("stall_out_hold", 4'hA, 1'b1, 1);
    tick(); check("stall_out_hold", 4'hA, 1'b1, 1);
    drive(1'b1, 1'b0, 1'b0, 4'h0); tick(); check("stall_drain", 4'h0, 1'b0, 0);

    // bubbles: valid 1,0,1 with d 5,F,6
    drive(1'b1, 1'b0, 1'b1, 4'h5); tick(); check("bub_e1", 4'h0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b0, 4'hF); tick(); check("bub_e2", 4'h0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b1, 4'h6); tick(); check("bub_out5", 4'h5, 1'b1, 2);
    drive(1'b1, 1'b0, 1'b0, 4'h0); tick(); check("bub_outF", 4'hF, 1'b0, 1);
    tick(); check("bub_out6", 4'h6, 1'b1, 1);
    tick(); check("bub_empty", 4'h0, 1'b0, 0);

    // flush beats en: 7,8 in flight, then flush with d=9 valid
    drive(1'b1, 1'b0, 1'b1, 4'h7); tick(); check("fl_load7", 4'h0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b1, 4'h8); tick(); check("fl_load8", 4'h0, 1'b0, 2);
    drive(1'b1, 1'b1, 1'b1, 4'h9); tick(); check("fl_flush", 4'h0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); check("fl_no9", 4'h0, 1'b0, 0);
    end

    // flush while stalled with a valid beat at the output
    drive(1'b1, 1'b0, 1'b1, 4'hB); tick();
    drive(1'b1, 1'b0, 1'b0, 4'h0); tick();
    tick(); check("fl_stall_pre", 4'hB, 1'b1, 1);
    drive(1'b0, 1'b1, 1'b0, 4'h0); tick(); check("fl_stall", 4'h0, 1'b0, 0);

    // async reset mid-cycle with all stages full
    drive(1'b1, 1'b0, 1'b1, 4'hD); tick();
    drive(1'b1, 1'b0, 1'b1, 4'hE); tick();
    drive(1'b1, 1'b0, 1'b1, 4'hC); tick();
    check("full_pre_rst", 4'hD, 1'b1, 3);
    check1("full_pre_rst1", 4'hC, 1'b1, 1);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst", 4'h0, 1'b0, 0);
    check1("async_rst1", 4'h0, 1'b0, 0);
    tick();
    reset = 1'b0;

    // restart after reset release: first enabled edge captures d
    drive(1'b1, 1'b0, 1'b1, 4'h3); tick(); check("restart_e1", 4'h0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b0, 4'h0); tick(); check("restart_e2", 4'h0, 1'b0, 1);
    tick(); check("restart_out", 4'h3, 1'b1, 1);

    // DEPTH=1 instance: one-edge latency, en=0 holds
    drive(1'b1, 1'b0, 1'b1, 4'hC); tick(); check1("d1_load", 4'hC, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    tick(); check1("d1_hold", 4'hC, 1'b1, 1);
    tick(); check1("d1_hold", 4'hC, 1'b1, 1);
    drive(1'b1, 1'b0, 1'b0, 4'h2); tick(); check1("d1_bubble", 4'h2, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 4'h9); tick(); check1("d1_flush", 4'h0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_flopenr_pipe

// File: doc/flopenr_pipe.md
Name: flopenr_pipe

Overview:
- Parametrised successor to the 4-bit enabled, resettable flop.
- A DEPTH-stage, WIDTH-bit pipeline register with a per-stage valid bit, a global advance enable (stall when low) and a synchronous flush.
- Used as a generic delay/pipeline slice between datapath blocks that need stall and squash control.

Parameters:
- WIDTH, 4, data width in bits (≥1)
- DEPTH, 3, number of pipeline stages (≥1); latency in enabled cycles
- RESET_VAL, 0, WIDTH-bit value loaded into every data stage on reset or flush

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  advance enable; 0 = all stages hold
- flush  input  1  synchronous squash of all stages
- in_valid  input  1  qualifies d
- d  input  WIDTH  input data
- q  output  WIDTH  data of last stage
- out_valid  output  1  valid bit of last stage
- occ  output  $clog2(DEPTH+1)  valid-stage count; present only with FLOPENR_PIPE_OCC_EN

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on port reset.
- Reset (async, any time): every data stage = RESET_VAL, every valid bit = 0. So q = RESET_VAL and out_valid = 0 immediately, with no clock edge needed.
- Priority at each rising clk edge: reset > flush > en > hold.
- flush=1:
  - All data stages load RESET_VAL; all valid bits clear.
  - d/in_valid on that edge are discarded, even if en=1.
- en=1, flush=0:
  - stage[0] ← d, v[0] ← in_valid.
  - stage[i] ← stage[i-1], v[i] ← v[i-1] for i = 1..DEPTH-1.
  - Data shifts regardless of valid; invalid bubbles propagate as bubbles.
- en=0, flush=0: all stages and valid bits hold. in_valid is ignored and the value is lost; the upstream block must hold it.
- Latency: data accepted on enabled edge k appears on q after enabled edge k+DEPTH-1. Cycles with en=0 do not count.
- DEPTH=1: single flop with valid, equivalent to the legacy flop plus valid and flush.
- q and out_valid are registered outputs with no combinational path from inputs.
- Reset released mid-stream: the pipeline restarts empty; the first enabled edge after release captures d.

Optional Feature:
- Macro: FLOPENR_PIPE_OCC_EN.
- Defined:
  - Adds registered counter occ = number of set valid bits. Reset and flush set it to 0.
  - On en=1: occ ← occ + in_valid − v[DEPTH-1], for in-flight entries.
  - Never exceeds DEPTH and never underflows.
  - Bench assertion: occ equals the popcount of the valid bits every cycle.
- Undefined: the occ port and counter are absent; all other behaviour is identical.

Decomposition:
- Package flopenr_pkg holds:
  - function occ_width(depth) returning $clog2(depth+1), with minimum 1
  - default WIDTH/DEPTH constants
- One natural sub-module: flopenr_stage, a single WIDTH-bit data + valid register with en, flush and async reset. flopenr_pipe instantiates DEPTH of these in a generate loop.

Test Plan (WIDTH=4, DEPTH=3, RESET_VAL=0):
- Reset: assert reset mid-cycle with stages full → q=0x0 and out_valid=0 asynchronously; occ=0 with macro.
- Stream: en=1, in_valid=1, d=0x1,0x2,0x3,0x4 on consecutive edges → q=0x1 with out_valid=1 after the 3rd edge, then 0x2, 0x3, 0x4 on following edges.
- Stall: load 0xA, then drop en for 5 cycles → q/out_valid unchanged throughout; 0xA emerges after 2 more enabled edges once en returns to 1.
- Bubbles: in_valid pattern 1,0,1 with d=0x5,0xF,0x6 → out_valid pattern 1,0,1 with q=0x5,0xF,0x6; occ peaks at 2.
- Flush priority: pipeline holds 0x7,0x8, then flush=1, en=1, in_valid=1, d=0x9 → next edge all valid=0, q=0x0; 0x9 never appears.
- DEPTH=1 build: d=0xC, in_valid=1, en=1 → q=0xC, out_valid=1 after one edge; en=0 holds it.
